// File: rtl/and8_bist_checker.sv
// and8_bist_checker: on-chip stimulus generator and response checker for the
// and8 netlist. It applies all-zeros, then cumulative walking ones, then LFSR
// vectors. Each response is compared against a reduction-AND model, and the
// block reports a saturating mismatch count and the first failing vector.
module and8_bist_checker #(
    parameter int          WIDTH      = 8,
    parameter int          NUM_RANDOM = 3000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] stim,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_vec
);

    // Total vectors: all-zeros, WIDTH walking-ones masks, then the random tail
    localparam int NUM_VEC = 1 + WIDTH + NUM_RANDOM;
    localparam int IDX_W   = (NUM_VEC > 2) ? $clog2(NUM_VEC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
    // An all-zero seed would lock the LFSR, so it is replaced with 1
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      lfsr, lfsr_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [WIDTH-1:0] stim_nxt;
    logic             busy_nxt, done_nxt, pass_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ffv_nxt;
    logic [WIDTH-1:0] ffvec_nxt;
    logic             mismatch;

    // 16-bit right-shifting Galois LFSR, taps 16'hB400
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v[0])
            lfsr_step = (v >> 1) ^ 16'hB400;
        else
            lfsr_step = v >> 1;
    endfunction

    // Counter increment that sticks at all ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c)
            sat_inc = c;
        else
            sat_inc = c + CNT_W'(1);
    endfunction

    // Mask with the low k bits set, i.e. (1<<k)-1 without overflowing at k=WIDTH
    function automatic logic [WIDTH-1:0] ones_mask(input int k);
        logic [WIDTH-1:0] m;
        for (int i = 0; i < WIDTH; i++)
            m[i] = (i < k);
        ones_mask = m;
    endfunction

    assign mismatch = (dut_out != (&stim));

    // Next-state and next-output logic for the run sequencer
    always_comb begin
        state_nxt = state;
        stim_nxt  = stim;
        busy_nxt  = busy;
        done_nxt  = done;
        pass_nxt  = pass;
        cnt_nxt   = mismatch_cnt;
        ffv_nxt   = first_fail_valid;
        ffvec_nxt = first_fail_vec;
        lfsr_nxt  = lfsr;
        idx_nxt   = idx;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stim_nxt  = '0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    ffv_nxt   = 1'b0;
                    lfsr_nxt  = SEED;
                    idx_nxt   = '0;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                state_nxt = CHECK;
            end
            CHECK: begin
                if (mismatch) begin
                    cnt_nxt = sat_inc(mismatch_cnt);
                    if (!first_fail_valid) begin
                        ffv_nxt   = 1'b1;
                        ffvec_nxt = stim;
                    end
                end
                if (idx == LAST_IDX) begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (cnt_nxt == '0);
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                    if (int'(idx) < WIDTH) begin
                        stim_nxt = ones_mask(int'(idx) + 1);
                    end else begin
                        lfsr_nxt = lfsr_step(lfsr);
                        stim_nxt = lfsr_nxt[WIDTH-1:0];
                    end
                    state_nxt = SETTLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and status registers; reset aborts any run and clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            stim             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            lfsr             <= SEED;
            idx              <= '0;
        end else begin
            state            <= state_nxt;
            stim             <= stim_nxt;
            busy             <= busy_nxt;
            done             <= done_nxt;
            pass             <= pass_nxt;
            mismatch_cnt     <= cnt_nxt;
            first_fail_valid <= ffv_nxt;
            first_fail_vec   <= ffvec_nxt;
            lfsr             <= lfsr_nxt;
            idx              <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_and8_bist_checker.sv
// Directed bench for and8_bist_checker: golden, stuck-at-0 and stuck-at-1
// responders, restart/ignore behaviour, CNT_W=2 saturation, and async reset.
module tb_and8_bist_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] stim;
    logic       dut_out;
    logic       busy, done, pass;
    logic [15:0] mismatch_cnt;
    logic       first_fail_valid;
    logic [7:0] first_fail_vec;

    logic [7:0] stim2;
    logic       busy2, done2, pass2;
    logic [1:0] mismatch_cnt2;
    logic       ffv2;
    logic [7:0] ffvec2;

    int mode;   // 0 golden AND, 1 stuck-at-0, 2 stuck-at-1
    int checks;
    int fails;

    logic [7:0] exp_seq [13];

    and8_bist_checker #(
        .WIDTH(8), .NUM_RANDOM(4), .LFSR_SEED(16'hACE1), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec)
    );

    // Second checker with a 2-bit counter, always facing a stuck-at-1 responder
    and8_bist_checker #(
        .WIDTH(8), .NUM_RANDOM(4), .LFSR_SEED(16'hACE1), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim2), .dut_out(1'b1),
        .busy(busy2), .done(done2), .pass(pass2), .mismatch_cnt(mismatch_cnt2),
        .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
    );

    assign dut_out = (mode == 0) ? (&stim) : (mode == 1) ? 1'b0 : 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " stim"}, 32'(stim), 32'h0);
        check({tag, " busy"}, 32'(busy), 32'h0);
        check({tag, " done"}, 32'(done), 32'h0);
        check({tag, " pass"}, 32'(pass), 32'h0);
        check({tag, " cnt"}, 32'(mismatch_cnt), 32'h0);
        check({tag, " ffv"}, 32'(first_fail_valid), 32'h0);
        check({tag, " ffvec"}, 32'(first_fail_vec), 32'h0);
    endtask

    // One full run: start edge is cycle 0, samples #1 after each rising edge
    task automatic run(input string tag, input int pulse_at, input logic [15:0] e_cnt,
                       input logic e_ffv, input logic [7:0] e_ffvec, input logic e_pass);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " cleared cnt"}, 32'(mismatch_cnt), 32'h0);
        check({tag, " cleared ffv"}, 32'(first_fail_valid), 32'h0);
        check({tag, " busy at start"}, 32'(busy), 32'h1);
        for (int c = 0; c <= 27; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (c == pulse_at) start = 1'b1;
            if (c == pulse_at + 1) start = 1'b0;
            if ((c % 2 == 0) && (c / 2 < 13))
                check($sformatf("%s stim v%0d", tag, c / 2), 32'(stim), 32'(exp_seq[c / 2]));
            if (c == 25) check({tag, " done early"}, 32'(done), 32'h0);
            if (c == 26) begin
                check({tag, " done"}, 32'(done), 32'h1);
                check({tag, " busy end"}, 32'(busy), 32'h0);
                check({tag, " pass"}, 32'(pass), 32'(e_pass));
                check({tag, " cnt"}, 32'(mismatch_cnt), 32'(e_cnt));
                check({tag, " ffv"}, 32'(first_fail_valid), 32'(e_ffv));
                if (e_ffv) check({tag, " ffvec"}, 32'(first_fail_vec), 32'(e_ffvec));
            end
            if (c == 27) begin
                check({tag, " stim held"}, 32'(stim), 32'h4E);
                check({tag, " done held"}, 32'(done), 32'h1);
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        mode   = 0;
        start  = 1'b0;
        rst_n  = 1'b0;
        exp_seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                    8'hFF, 8'h70, 8'h38, 8'h9C, 8'h4E};

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle no start busy", 32'(busy), 32'h0);
        check("idle no start stim", 32'(stim), 32'h0);

        mode = 0;
        run("golden", -1, 16'd0, 1'b0, 8'h00, 1'b1);

        mode = 1;
        run("sa0", -1, 16'd1, 1'b1, 8'hFF, 1'b0);

        mode = 2;
        run("sa1", -1, 16'd12, 1'b1, 8'h00, 1'b0);
        check("sat cnt_w2", 32'(mismatch_cnt2), 32'h3);
        check("sat pass", 32'(pass2), 32'h0);

        mode = 0;
        run("restart ignored", 10, 16'd0, 1'b0, 8'h00, 1'b1);

        // Async reset mid-CHECK with a faulty responder so status is non-zero
        mode = 2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre-reset cnt", 32'(mismatch_cnt), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("async reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post-reset idle busy", 32'(busy), 32'h0);

        mode = 0;
        run("after reset", -1, 16'd0, 1'b0, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
